// File: rtl/miner_pkg.sv
// miner_pkg: shared definitions for the SHA-256 miner message path.
//   BLOCK_W      - message block width in bits
//   WORD_W       - host word width in bits
//   asm_state_e  - block assembler states (FILL, HOLD)
//   byte_reverse - reverses the byte order of one WORD_W word
package miner_pkg;

   localparam int unsigned BLOCK_W = 512;
   localparam int unsigned WORD_W  = 32;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } asm_state_e;

   function automatic logic [WORD_W-1:0] byte_reverse(input logic [WORD_W-1:0] w);
      logic [WORD_W-1:0] r;
      r = '0;
      for (int unsigned b = 0; b < WORD_W / 8; b++) begin
         r[b*8 +: 8] = w[WORD_W-8-b*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/word_byteswap.sv
// word_byteswap: purely combinational byte-order reversal of one word.
//   WORD      - word width in bits (multiple of 8)
//   in_word   - input word
//   out_word  - in_word with its byte order reversed
module word_byteswap
   import miner_pkg::*;
#(
   parameter int unsigned WORD = WORD_W
) (
   input  logic [WORD-1:0] in_word,
   output logic [WORD-1:0] out_word
);

   generate
      if (WORD == WORD_W) begin : g_pkg_fn
         assign out_word = byte_reverse(in_word);
      end else begin : g_generic
         always_comb begin
            out_word = '0;
            for (int unsigned b = 0; b < WORD / 8; b++) begin
               out_word[b*8 +: 8] = in_word[WORD-8-b*8 +: 8];
            end
         end
      end
   endgenerate

endmodule

// File: rtl/block_assembler.sv
// block_assembler: gathers WORD-bit host words into one LENGTH-bit message
// block, first word at the most-significant position, and holds the block
// stable until the consumer accepts it.
//   clk, rst     - rising-edge clock, asynchronous active-high reset
//   clear        - synchronous abort of any partial or held block
//   in_data/in_valid/in_ready         - word input handshake
//   block_data/block_valid/block_ready - block output handshake
//   word_count   - words stored in the current block (WORDS when held)
// Build option: define INPUT_BYTESWAP_EN to byte-reverse each word before
// it is stored (word order, handshake and timing are unchanged).
module block_assembler
   import miner_pkg::*;
#(
   parameter int unsigned LENGTH = BLOCK_W,
   parameter int unsigned WORD   = WORD_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic [WORD-1:0]               in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [LENGTH-1:0]             block_data,
   output logic                          block_valid,
   input  logic                          block_ready,
   output logic [$clog2(LENGTH/WORD):0]  word_count
);

   localparam int unsigned WORDS = LENGTH / WORD;
   localparam int unsigned CW    = $clog2(WORDS) + 1;

   asm_state_e        state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [LENGTH-1:0] data_q,  data_d;
   logic              valid_q, valid_d;
   logic [WORD-1:0]   store_word;
   logic              accept;

`ifdef INPUT_BYTESWAP_EN
   word_byteswap #(.WORD(WORD)) u_byteswap (
      .in_word  (in_data),
      .out_word (store_word)
   );
`else
   assign store_word = in_data;
`endif

   // Depends only on state and rst so no path exists from in_valid/block_ready.
   assign in_ready    = !rst && (state_q == FILL);
   assign accept      = in_valid && in_ready;
   assign block_data  = data_q;
   assign block_valid = valid_q;
   assign word_count  = count_q;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (clear) begin
         // block_data deliberately left untouched; only the bookkeeping resets.
         state_d = FILL;
         count_d = '0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            FILL: begin
               if (accept) begin
                  for (int unsigned i = 0; i < WORDS; i++) begin
                     if (count_q == CW'(i)) begin
                        data_d[LENGTH-1-i*WORD -: WORD] = store_word;
                     end
                  end
                  count_d = count_q + CW'(1);
                  if (count_q == CW'(WORDS - 1)) begin
                     state_d = HOLD;
                     valid_d = 1'b1;
                  end
               end
            end
            HOLD: begin
               if (block_ready) begin
                  state_d = FILL;
                  count_d = '0;
                  valid_d = 1'b0;
               end
            end
            default: begin
               state_d = FILL;
               count_d = '0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
         count_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_block_assembler.sv
module tb_block_assembler;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         clear = 1'b0;
   logic [31:0]  in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [511:0] block_data;
   logic         block_valid;
   logic         block_ready = 1'b0;
   logic [4:0]   word_count;

   int checks = 0;
   int errors = 0;

   // Reference model: words collected so far, held flag, expected blocks.
   logic [31:0]  words[$];
   logic [511:0] exp_q[$];
   bit           hold = 1'b0;
   bit           model_rst = 1'b0;
   bit           mon_en = 1'b0;
   bit           prev_valid = 1'b0;

   block_assembler dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .block_data  (block_data),
      .block_valid (block_valid),
      .block_ready (block_ready),
      .word_count  (word_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef INPUT_BYTESWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   // One clock cycle of stimulus; called and returns at a falling edge.
   task automatic cycle(input logic v, input logic [31:0] d, input logic br, input logic clr);
      logic [511:0] blk;
      in_valid = v;
      in_data = d;
      block_ready = br;
      clear = clr;
      @(posedge clk);
      if (clr) begin
         words.delete();
         hold = 1'b0;
      end else if (hold) begin
         if (br) hold = 1'b0;
      end else if (v) begin
         words.push_back(d);
         if (words.size() == 16) begin
            blk = '0;
            foreach (words[i]) blk = {blk[479:0], stored(words[i])};
            exp_q.push_back(blk);
            words.delete();
            hold = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic release_block();
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic send_words(input logic [31:0] base, input int n, input bit br);
      for (int k = 0; k < n; k++) cycle(1'b1, base + k, br, 1'b0);
   endtask

   task automatic async_reset(input string tag);
      in_valid = 1'b0;
      block_ready = 1'b0;
      clear = 1'b0;
      #2;
      rst = 1'b1;
      model_rst = 1'b1;
      words.delete();
      hold = 1'b0;
      #1;
      check({tag, "_valid"}, 512'(block_valid), 512'(0));
      check({tag, "_count"}, 512'(word_count), 512'(0));
      check({tag, "_data"}, block_data, '0);
      check({tag, "_ready"}, 512'(in_ready), 512'(0));
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
      model_rst = 1'b0;
      @(negedge clk);
   endtask

   // Monitor: per-cycle handshake/count checks and block scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         check("mon_word_count", 512'(word_count), 512'(hold ? 16 : words.size()));
         check("mon_in_ready", 512'(in_ready), 512'(!model_rst && !hold));
         check("mon_block_valid", 512'(block_valid), 512'(hold));
         if (block_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got block %h expected none", block_data);
            end else begin
               check("sb_block", block_data, exp_q.pop_front());
            end
         end
         prev_valid = block_valid;
      end
   end

   initial begin
      logic [31:0] r[16];
      int idx;
      bit v;

      #1;
      rst = 1'b1;
      model_rst = 1'b1;
      #1;
      check("rst_valid", 512'(block_valid), 512'(0));
      check("rst_count", 512'(word_count), 512'(0));
      check("rst_data", block_data, '0);
      check("rst_ready", 512'(in_ready), 512'(0));
      @(negedge clk);
      #2;
      rst = 1'b0;
      model_rst = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;

      // Gapless block 0..15, held by the consumer.
      send_words(32'h0, 16, 1'b0);
      check("a_top", 512'(block_data[511:480]), 512'(stored(32'h0)));
      check("a_bottom", 512'(block_data[31:0]), 512'(stored(32'hF)));
      check("a_count", 512'(word_count), 512'(16));
      check("a_ready", 512'(in_ready), 512'(0));
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      release_block();
      check("rel_valid", 512'(block_valid), 512'(0));
      check("rel_ready", 512'(in_ready), 512'(1));
      check("rel_count", 512'(word_count), 512'(0));

      // Second block 0xA0000000+k.
      send_words(32'hA000_0000, 16, 1'b0);
      idle();
      release_block();

      // Random gaps with random (ignored) block_ready, then same words gapless.
      foreach (r[i]) r[i] = $urandom;
      idx = 0;
      while (idx < 16) begin
         v = bit'($urandom_range(1));
         cycle(v, r[idx], 1'($urandom_range(1)), 1'b0);
         if (v) idx++;
      end
      release_block();
      foreach (r[i]) cycle(1'b1, r[i], 1'b0, 1'b0);
      release_block();

      // clear after 7 words, with a word presented in the clear cycle.
      send_words(32'h1111_0000, 7, 1'b0);
      cycle(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b1);
      check("clr_count", 512'(word_count), 512'(0));
      send_words(32'h2222_0000, 16, 1'b0);
      check("clr_top", 512'(block_data[511:480]), 512'(stored(32'h2222_0000)));
      release_block();

      // Asynchronous reset mid-block and in HOLD.
      send_words(32'h3333_0000, 9, 1'b0);
      check("mid_count", 512'(word_count), 512'(9));
      async_reset("rst_mid");
      send_words(32'h4444_0000, 16, 1'b0);
      idle();
      async_reset("rst_hold");

      // Byte-order check on a known word.
      cycle(1'b1, 32'h6162_6364, 1'b0, 1'b0);
      send_words(32'h5555_0000, 15, 1'b0);
`ifdef INPUT_BYTESWAP_EN
      check("swap_top", 512'(block_data[511:480]), 512'(32'h6463_6261));
`else
      check("swap_top", 512'(block_data[511:480]), 512'(32'h6162_6364));
`endif
      release_block();

      // Back-to-back blocks at the minimum period with block_ready held high.
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < 16; k++) cycle(1'b1, $urandom, 1'b1, 1'b0);
         cycle(1'b0, 32'h0, 1'b1, 1'b0);
      end

      idle();
      idle();
      check("sb_drained", 512'(exp_q.size()), 512'(0));
      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
